// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first. The SPI pins are
//            oversampled on clk. Received words are assembled into rx_data_o.
//            A one-deep holding register feeds the transmit shifter.
// Ports    : clk_i, rst_i         system clock, synchronous active-high reset
//            sclk_i, cs_n_i       SPI clock / chip select (asynchronous)
//            mosi_i, miso_o       serial data in / out
//            tx_data_i, tx_wr_i   write port of the transmit holding register
//            tx_ready_o           holding register empty
//            rx_data_o            last complete received word
//            rx_valid_o           one-cycle pulse when rx_data_o updates
//            busy_o               frame in progress
//            frame_err_o          (SPI_SLV_FRAME_ERR_EN only) pulses when a
//                                 frame ends with a partial word
// Options  : `define SPI_SLV_FRAME_ERR_EN to add the frame_err_o output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_wr_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
`ifdef SPI_SLV_FRAME_ERR_EN
  ,
  output logic              frame_err_o
`endif
);

  localparam int              CNT_W       = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] C_WORD_BITS = CNT_W'(DATA_W);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Pin synchronisers. The cs_n chain resets to 0 so that cs_n held low
  // through reset does not look like a falling edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;

  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic [DATA_W-1:0] hold_q,     hold_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic              full_q, full_d;
  logic              word_done_q, word_done_d;
  logic              rx_valid_q, rx_valid_d;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic              frame_err_q, frame_err_d;
`endif

  logic             sclk_s, cs_s, mosi_s;
  logic             sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic             load;
  logic [CNT_W-1:0] cnt_base;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      bit_cnt_q   <= '0;
      full_q      <= 1'b0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      bit_cnt_q   <= bit_cnt_d;
      full_q      <= full_d;
      word_done_q <= word_done_d;
      rx_valid_q  <= rx_valid_d;
`ifdef SPI_SLV_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    bit_cnt_d   = bit_cnt_q;
    full_d      = full_q;
    word_done_d = word_done_q;
    rx_valid_d  = 1'b0;
    load        = 1'b0;
    cnt_base    = bit_cnt_q;
`ifdef SPI_SLV_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d   = '0;
        word_done_d = 1'b0;
        if (cs_fall) begin
          load    = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // A full word is published one cycle after the last bit is shifted
        // in; a complete word is published even if cs_n rises now.
        if (bit_cnt_q == C_WORD_BITS) begin
          rx_data_d   = rx_shift_q;
          rx_valid_d  = 1'b1;
          word_done_d = 1'b1;
          bit_cnt_d   = '0;
          cnt_base    = '0;
        end
        if (cs_rise) begin
          // cs_n rising overrides any coincident sclk edge.
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
          frame_err_d = (bit_cnt_q != '0) && (bit_cnt_q != C_WORD_BITS);
`endif
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_d  = cnt_base + CNT_W'(1);
        end else if (sclk_fall) begin
          if (word_done_q) begin
            load        = 1'b1;
            word_done_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load reads the pre-write holding contents; a same-cycle write then
    // leaves the new byte held.
    if (load) begin
      tx_shift_d = full_q ? hold_q : '0;
      full_d     = 1'b0;
    end
    if (tx_wr_i) begin
      hold_d = tx_data_i;
      full_d = 1'b1;
    end
  end

  assign busy_o     = (state_q == ST_ACTIVE);
  assign miso_o     = (state_q == ST_ACTIVE) & tx_shift_q[DATA_W-1];
  assign tx_ready_o = ~full_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
`ifdef SPI_SLV_FRAME_ERR_EN
  assign frame_err_o = frame_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave. The bench plays the SPI
//            master (sclk half period = 4 clk) and keeps a word-level model
//            of the transmit holding register and of the received words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst, sclk, cs_n, mosi, miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_wr, tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, busy;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic              frame_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: holding register and last received word.
  logic [7:0] m_hold;
  bit         m_full;
  logic [7:0] m_rx_last;

  logic [7:0] rx_q[$];
  int         fe_cnt = 0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sclk_i     (sclk),
    .cs_n_i     (cs_n),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .tx_data_i  (tx_data),
    .tx_wr_i    (tx_wr),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .busy_o     (busy)
`ifdef SPI_SLV_FRAME_ERR_EN
    ,
    .frame_err_o(frame_err)
`endif
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_q.push_back(rx_data);
`ifdef SPI_SLV_FRAME_ERR_EN
    if (frame_err === 1'b1) fe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
    m_hold  = d;
    m_full  = 1'b1;
    @(negedge clk);
  endtask

  // Clock nbits bits out of mo (MSB first from bit 15); miso is sampled just
  // before each rising edge. Optionally strobes tx_wr during bit 3's high phase.
  task automatic send_bits(input int nbits, input logic [15:0] mo, input bit mid_wr,
                           input logic [7:0] mid_d, output logic [15:0] mi, output int bhi);
    mi  = '0;
    bhi = 0;
    for (int b = 0; b < nbits; b++) begin
      mosi = mo[15-b];
      repeat (4) @(negedge clk);
      mi[15-b] = miso;
      if (busy === 1'b1) bhi++;
      sclk = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (mid_wr && b == 3 && k == 0) begin
          tx_data = mid_d;
          tx_wr   = 1'b1;
        end
        @(negedge clk);
        tx_wr = 1'b0;
      end
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input int nbits, input logic [15:0] mo, input bit start_wr,
                       input logic [7:0] start_d, input bit mid_wr, input logic [7:0] mid_d,
                       output logic [15:0] mi, output int bhi);
    cs_n = 1'b0;
    if (start_wr) begin
      // Strobe lands on the clk edge where the synchronised cs_n fall loads.
      repeat (SYNC_STAGES) @(negedge clk);
      tx_data = start_d;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr   = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    send_bits(nbits, mo, mid_wr, mid_d, mi, bhi);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Full-word frame: model predicts the byte the master sees in each word
  // slot (one load at frame start, one at the end of every word) and the
  // received words, then everything is compared.
  task automatic run_frame(input string tag, input int nw, input logic [15:0] mo,
                           input bit sw, input logic [7:0] sd, input bit mw, input logic [7:0] md);
    logic [7:0]  exp_w[3];
    logic [15:0] mi;
    int          bhi;
    int          fe0;
    exp_w[0] = m_full ? m_hold : 8'h00;
    m_full   = 1'b0;
    if (sw) begin m_hold = sd; m_full = 1'b1; end
    for (int k = 0; k < nw; k++) begin
      if (k == 0 && mw) begin m_hold = md; m_full = 1'b1; end
      exp_w[k+1] = m_full ? m_hold : 8'h00;
      m_full     = 1'b0;
    end
    fe0 = fe_cnt;
    rx_q.delete();
    frame(nw * 8, mo, sw, sd, mw, md, mi, bhi);
    for (int k = 0; k < nw; k++) begin
      check($sformatf("%s master_rx[%0d]", tag, k), 32'(mi[15-8*k -: 8]), 32'(exp_w[k]));
    end
    check({tag, " rx_valid_count"}, 32'(rx_q.size()), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      if (k < rx_q.size())
        check($sformatf("%s rx_word[%0d]", tag, k), 32'(rx_q[k]), 32'(mo[15-8*k -: 8]));
    end
    m_rx_last = mo[15-8*(nw-1) -: 8];
    check({tag, " rx_data"},    32'(rx_data),  32'(m_rx_last));
    check({tag, " busy_frame"}, 32'(bhi),      32'(nw * 8));
    check({tag, " busy_idle"},  32'(busy),     32'(0));
    check({tag, " tx_ready"},   32'(tx_ready), 32'(!m_full));
    check({tag, " frame_err"},  32'(fe_cnt - fe0), 32'(0));
  endtask

  initial begin
    logic [15:0] mi;
    int          bhi;
    int          fe0;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_wr = 1'b0;
    m_hold = '0; m_full = 1'b0; m_rx_last = '0;
    repeat (3) @(negedge clk);
    check("reset miso",     32'(miso),     32'(0));
    check("reset tx_ready", 32'(tx_ready), 32'(1));
    check("reset rx_data",  32'(rx_data),  32'(0));
    check("reset rx_valid", 32'(rx_valid), 32'(0));
    check("reset busy",     32'(busy),     32'(0));
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Basic exchange.
    wr(8'hA5);
    check("t1 tx_ready_full", 32'(tx_ready), 32'(0));
    run_frame("t1", 1, 16'h3C00, 1'b0, 8'h00, 1'b0, 8'h00);

    // Two words with a refill during word 1.
    wr(8'hA5);
    run_frame("t2", 2, 16'h1234, 1'b0, 8'h00, 1'b1, 8'h81);

    // Underrun.
    run_frame("t3", 1, 16'hFF00, 1'b0, 8'h00, 1'b0, 8'h00);

    // Partial word: 5 bits then cs_n high.
    rx_q.delete();
    fe0    = fe_cnt;
    m_full = 1'b0;
    frame(5, 16'hB800, 1'b0, 8'h00, 1'b0, 8'h00, mi, bhi);
    check("t4 rx_valid_count", 32'(rx_q.size()), 32'(0));
    check("t4 busy",           32'(busy),        32'(0));
    check("t4 rx_data",        32'(rx_data),     32'(m_rx_last));
`ifdef SPI_SLV_FRAME_ERR_EN
    check("t4 frame_err", 32'(fe_cnt - fe0), 32'(1));
`else
    check("t4 frame_err", 32'(fe_cnt - fe0), 32'(0));
`endif

    // Reset mid-byte with cs_n held low.
    rx_q.delete();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(3, 16'hA000, 1'b0, 8'h00, mi, bhi);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_full = 1'b0; m_rx_last = '0;
    check("t5 miso",     32'(miso),     32'(0));
    check("t5 tx_ready", 32'(tx_ready), 32'(1));
    check("t5 rx_data",  32'(rx_data),  32'(0));
    check("t5 rx_valid", 32'(rx_valid), 32'(0));
    check("t5 busy",     32'(busy),     32'(0));
    send_bits(8, 16'h5A00, 1'b0, 8'h00, mi, bhi);
    repeat (8) @(negedge clk);
    check("t5 no_frame_busy", 32'(bhi),         32'(0));
    check("t5 no_frame_rx",   32'(rx_q.size()), 32'(0));
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    run_frame("t5", 1, 16'hC300, 1'b0, 8'h00, 1'b0, 8'h00);

    // Last write wins; write coincident with the frame-start load.
    wr(8'h11);
    wr(8'h22);
    run_frame("t6a", 1, 16'h5500, 1'b0, 8'h00, 1'b0, 8'h00);
    run_frame("t6b", 2, 16'h6699, 1'b1, 8'h9E, 1'b0, 8'h00);
    check("t6b tx_ready_after", 32'(tx_ready), 32'(1));

    // Randomised frames.
    for (int r = 0; r < 6; r++) begin
      int npre;
      npre = $urandom_range(0, 2);
      for (int p = 0; p < npre; p++) wr(8'($urandom));
      run_frame($sformatf("rnd%0d", r), $urandom_range(1, 2), 16'($urandom),
                1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) slave, MSB-first, sitting on the far end of the existing SPI master bus (sclk, mosi, miso, cs_n).
- Oversamples the SPI pins on the system clock, assembles received bytes, and serialises a one-deep buffered transmit byte.
- Used as the DUT-side responder for master loopback benches and as a reusable peripheral endpoint.

Parameters:
DATA_W, 8, bits per SPI word; MSB shifted first.
SYNC_STAGES, 2, flops in each pin synchroniser (sclk, cs_n, mosi); minimum 2.

Ports:
clk  in  1  system clock; must run at least 4x sclk (master CLK_DIV=4 gives clk/8).
rst  in  1  synchronous, active-high reset.
sclk  in  1  SPI clock from master, asynchronous to clk.
cs_n  in  1  chip select, active low, asynchronous.
mosi  in  1  master-out serial data.
miso  out  1  slave-out serial data.
tx_data  in  DATA_W  byte to send in the next word slot.
tx_wr  in  1  one-cycle write strobe for tx_data into the holding register.
tx_ready  out  1  holding register empty.
rx_data  out  DATA_W  last fully received word; held until the next word completes.
rx_valid  out  1  one-cycle pulse when rx_data updates.
busy  out  1  frame in progress (state ACTIVE).

Behaviour:
- Sync: sclk, cs_n and mosi each pass through SYNC_STAGES flops plus one delay flop for edge detection. Reset values: sclk chain 0, mosi chain 0, cs_n chain 0 (unarmed).
- Edges: sclk_rise, sclk_fall and cs_fall/cs_rise are derived from the last sync stage and its delay flop.
- FSM, IDLE:
  - miso=0, bit_cnt=0.
  - On cs_fall: load tx_shift from the holding register, or 0x00 if empty; clear holding full; go ACTIVE.
  - A frame starts only on a high-to-low cs_n transition. After reset with cs_n held low, the block stays IDLE until cs_n goes high then low.
- FSM, ACTIVE:
  - miso = tx_shift[DATA_W-1].
  - sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi}; bit_cnt++.
  - When bit_cnt reaches DATA_W: rx_data <= assembled word; rx_valid=1 for the following cycle; bit_cnt=0; set word_done.
  - sclk_fall with word_done: load tx_shift from the holding register (0x00 if empty), clear holding full and word_done.
  - sclk_fall otherwise: tx_shift <<= 1.
  - cs_rise: go IDLE and discard any partial word. No rx_valid is issued for a partial word.
- Latency: rx_valid is asserted SYNC_STAGES+2 clk cycles after the DATA_W-th sclk rising edge at the pin.
- Holding register:
  - tx_wr sets full and tx_ready=0.
  - tx_wr while full overwrites the held byte (last write wins).
  - tx_wr in the same cycle as a load: the load takes the pre-write contents, and the new byte stays held (full=1).
- Simultaneous cs_rise and sclk edge: cs_rise wins; the edge is ignored.
- busy = (state==ACTIVE).
- Reset values: miso 0, tx_ready 1, rx_data 0, rx_valid 0, busy 0, FSM IDLE, all shift registers and counters 0.
- Reset mid-frame aborts the frame with no rx_valid.

Optional Feature:
- Macro SPI_SLV_FRAME_ERR_EN.
- Defined: adds output frame_err (1 bit, reset 0). It pulses for one cycle when cs_rise occurs in ACTIVE with bit_cnt != 0. frame_err is not raised for a cs_rise at a word boundary.
- Undefined: the frame_err port is absent and partial words are discarded silently.

Test Plan:
1. Write tx_wr 0xA5 while IDLE; the master (CLK_DIV=4) sends 0x3C -> rx_data=0x3C with one rx_valid pulse, master rx_data=0xA5, tx_ready returns 1 at cs_fall.
2. Two-word frame: mosi 0x12, 0x34; tx_wr 0xA5 before the frame and 0x81 during word 1 -> rx_valid pulses twice with 0x12 then 0x34; miso carries 0xA5 then 0x81; busy=1 for the whole frame.
3. Underrun: no tx_wr; master sends 0xFF -> master receives 0x00, rx_data=0xFF.
4. cs_n deasserted after 5 sclk rises -> no rx_valid, busy=0, rx_data unchanged. With SPI_SLV_FRAME_ERR_EN: exactly one frame_err pulse.
5. rst asserted for 1 cycle mid-byte with cs_n held low -> all outputs at reset values. No frame until cs_n goes high then low; the next frame sending 0xC3 gives rx_data=0xC3.
6. Two tx_wr strobes (0x11 then 0x22) before cs_fall -> master receives 0x22. A tx_wr coincident with cs_fall on an empty register -> master receives 0x00 for word 1 and the written byte in word 2.
